// File: rtl/wb_arb_pkg.sv
// Shared constants, state encoding and bus payload type for the Wishbone bus arbiter.
package wb_arb_pkg;

    localparam int unsigned DATA_W         = 16;
    localparam int unsigned ADR_W          = 16;
    localparam int unsigned SEL_W          = 2;
    localparam int unsigned N_DMA          = 2;
    localparam int unsigned CNT_W          = 8;
    localparam int unsigned TMO_CYCLES_DEF = 64;

    localparam int unsigned DMA0_IDX = 0;
    localparam int unsigned DMA1_IDX = 1;

    typedef enum logic [1:0] {
        ST_CPU      = 2'd0,
        ST_DMA0     = 2'd1,
        ST_DMA1     = 2'd2,
        ST_HANDBACK = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic              cyc;
        logic              stb;
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] dat;
    } wb_req_t;

    // Extract one DMA master's request from the packed per-master input vectors.
    function automatic wb_req_t dma_payload(
        input logic                      hi,
        input logic [N_DMA-1:0]          stb,
        input logic [N_DMA-1:0]          we,
        input logic [N_DMA*SEL_W-1:0]    sel,
        input logic [N_DMA*ADR_W-1:0]    adr,
        input logic [N_DMA*DATA_W-1:0]   dat
    );
        wb_req_t p;
        p.cyc = 1'b1;
        if (hi) begin
            p.stb = stb[DMA1_IDX];
            p.we  = we[DMA1_IDX];
            p.sel = sel[SEL_W*DMA1_IDX +: SEL_W];
            p.adr = adr[ADR_W*DMA1_IDX +: ADR_W];
            p.dat = dat[DATA_W*DMA1_IDX +: DATA_W];
        end else begin
            p.stb = stb[DMA0_IDX];
            p.we  = we[DMA0_IDX];
            p.sel = sel[SEL_W*DMA0_IDX +: SEL_W];
            p.adr = adr[ADR_W*DMA0_IDX +: ADR_W];
            p.dat = dat[DATA_W*DMA0_IDX +: DATA_W];
        end
        return p;
    endfunction

endpackage

// File: rtl/wb_bus_watchdog.sv
// Bus-timeout watchdog: forces a one-cycle ack after TMO_CYCLES consecutive
// strobed-but-unacked cycles, so a missing device never hangs a master.
module wb_bus_watchdog
    import wb_arb_pkg::*;
#(
    parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEF
) (
    input  logic clk_p,
    input  logic rst_n,
    input  logic stb_i,
    input  logic ack_i,
    input  logic state_chg_i,
    output logic tmo_c
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stall;

    // A real ack in the same cycle suppresses the timeout.
    always_comb begin
        stall = stb_i & ~ack_i;
        tmo_c = stall & (cnt_q == CNT_LAST);
        cnt_d = cnt_q;
        if (!stall || state_chg_i || tmo_c) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Shares the 16-bit Wishbone system bus between the CPU and two DMA masters,
// switching only at cycle boundaries and round-robining between DMA requesters.
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEF
) (
    input  logic                      clk_p,
    input  logic                      rst_n,

    input  logic                      cpu_cyc_i,
    input  logic                      cpu_stb_i,
    input  logic                      cpu_we_i,
    input  logic [SEL_W-1:0]          cpu_sel_i,
    input  logic [ADR_W-1:0]          cpu_adr_i,
    input  logic [DATA_W-1:0]         cpu_dat_i,
    output logic                      cpu_gnt_o,
    output logic                      cpu_ack_o,

    input  logic [N_DMA-1:0]          dma_req_i,
    output logic [N_DMA-1:0]          dma_gnt_o,
    input  logic [N_DMA-1:0]          dma_stb_i,
    input  logic [N_DMA-1:0]          dma_we_i,
    input  logic [N_DMA*SEL_W-1:0]    dma_sel_i,
    input  logic [N_DMA*ADR_W-1:0]    dma_adr_i,
    input  logic [N_DMA*DATA_W-1:0]   dma_dat_i,
    output logic [N_DMA-1:0]          dma_ack_o,

    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [SEL_W-1:0]          wb_sel_o,
    output logic [ADR_W-1:0]          wb_adr_o,
    output logic [DATA_W-1:0]         wb_dat_o,
    input  logic                      wb_ack_i,
    output logic                      bus_tmo_o
);

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic             last_q;
    logic             last_d;
    logic             cpu_gnt_q;
    logic             cpu_gnt_d;
    logic [N_DMA-1:0] dma_gnt_q;
    logic [N_DMA-1:0] dma_gnt_d;

    wb_req_t          bus_c;
    logic             state_chg_c;
    logic             tmo_c;
    logic             ack_c;

    // CPU yields only between cycles; a DMA owner keeps the bus while its strobe is pending.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            ST_CPU: begin
                if (!cpu_cyc_i && (dma_req_i != '0)) begin
                    if (dma_req_i == 2'b11) begin
                        state_d = last_q ? ST_DMA0 : ST_DMA1;
                    end else begin
                        state_d = dma_req_i[DMA0_IDX] ? ST_DMA0 : ST_DMA1;
                    end
                end
            end
            ST_DMA0: begin
                if (!dma_req_i[DMA0_IDX] && !dma_stb_i[DMA0_IDX]) begin
                    state_d = ST_HANDBACK;
                end
            end
            ST_DMA1: begin
                if (!dma_req_i[DMA1_IDX] && !dma_stb_i[DMA1_IDX]) begin
                    state_d = ST_HANDBACK;
                end
            end
            ST_HANDBACK: state_d = ST_CPU;
            default:     state_d = ST_CPU;
        endcase

        if (state_d == ST_DMA0 && state_q != ST_DMA0) begin
            last_d = 1'b0;
        end else if (state_d == ST_DMA1 && state_q != ST_DMA1) begin
            last_d = 1'b1;
        end

        cpu_gnt_d   = (state_d == ST_CPU);
        dma_gnt_d   = {state_d == ST_DMA1, state_d == ST_DMA0};
        state_chg_c = (state_d != state_q);
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CPU;
            last_q    <= 1'b1;
            cpu_gnt_q <= 1'b1;
            dma_gnt_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cpu_gnt_q <= cpu_gnt_d;
            dma_gnt_q <= dma_gnt_d;
        end
    end

    // Bus request mux, selected by the registered owner; HANDBACK drives an idle bus.
    always_comb begin
        bus_c = '0;
        unique case (state_q)
            ST_CPU: begin
                bus_c.cyc = cpu_cyc_i;
                bus_c.stb = cpu_stb_i;
                bus_c.we  = cpu_we_i;
                bus_c.sel = cpu_sel_i;
                bus_c.adr = cpu_adr_i;
                bus_c.dat = cpu_dat_i;
            end
            ST_DMA0: bus_c = dma_payload(1'b0, dma_stb_i, dma_we_i, dma_sel_i, dma_adr_i, dma_dat_i);
            ST_DMA1: bus_c = dma_payload(1'b1, dma_stb_i, dma_we_i, dma_sel_i, dma_adr_i, dma_dat_i);
            ST_HANDBACK: bus_c = '0;
            default:     bus_c = '0;
        endcase
    end

    wb_bus_watchdog #(
        .TMO_CYCLES (TMO_CYCLES)
    ) u_watchdog (
        .clk_p       (clk_p),
        .rst_n       (rst_n),
        .stb_i       (bus_c.stb),
        .ack_i       (wb_ack_i),
        .state_chg_i (state_chg_c),
        .tmo_c       (tmo_c)
    );

    // Ack goes only to the current owner; a stray ack during HANDBACK is dropped.
    always_comb begin
        ack_c     = wb_ack_i | tmo_c;
        cpu_ack_o = 1'b0;
        dma_ack_o = '0;
        unique case (state_q)
            ST_CPU:      cpu_ack_o           = ack_c;
            ST_DMA0:     dma_ack_o[DMA0_IDX] = ack_c;
            ST_DMA1:     dma_ack_o[DMA1_IDX] = ack_c;
            ST_HANDBACK: dma_ack_o           = '0;
            default:     dma_ack_o           = '0;
        endcase
    end

    assign cpu_gnt_o = cpu_gnt_q;
    assign dma_gnt_o = dma_gnt_q;
    assign bus_tmo_o = tmo_c;

    assign wb_cyc_o  = bus_c.cyc;
    assign wb_stb_o  = bus_c.stb;
    assign wb_we_o   = bus_c.we;
    assign wb_sel_o  = bus_c.sel;
    assign wb_adr_o  = bus_c.adr;
    assign wb_dat_o  = bus_c.dat;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural ownership model.
module tb_wb_bus_arbiter;

    localparam int TMO      = 64;
    localparam int OWN_CPU  = -1;
    localparam int OWN_IDLE = -2;

    logic        clk_p = 1'b0;
    logic        rst_n = 1'b1;
    logic        cpu_cyc_i = 1'b0, cpu_stb_i = 1'b0, cpu_we_i = 1'b0;
    logic [1:0]  cpu_sel_i = '0;
    logic [15:0] cpu_adr_i = '0, cpu_dat_i = '0;
    logic        cpu_gnt_o, cpu_ack_o;
    logic [1:0]  dma_req_i = '0, dma_stb_i = '0, dma_we_i = '0;
    logic [3:0]  dma_sel_i = '0;
    logic [31:0] dma_adr_i = '0, dma_dat_i = '0;
    logic [1:0]  dma_gnt_o, dma_ack_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [1:0]  wb_sel_o;
    logic [15:0] wb_adr_o, wb_dat_o;
    logic        wb_ack_i = 1'b0;
    logic        bus_tmo_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who owns the bus, which DMA master was served last, length of current stall run.
    int m_own  = OWN_CPU;
    int m_last = 1;
    int m_run  = 0;

    int   toks[7];
    int   exp_tok[7];
    int   ntok, prev, tok;
    logic [1:0] done;
    logic stall_mode;
    int   ack_pct;
    logic e_t;

    always #5 clk_p = ~clk_p;

    wb_bus_arbiter #(.TMO_CYCLES(TMO)) dut (
        .clk_p     (clk_p),
        .rst_n     (rst_n),
        .cpu_cyc_i (cpu_cyc_i),
        .cpu_stb_i (cpu_stb_i),
        .cpu_we_i  (cpu_we_i),
        .cpu_sel_i (cpu_sel_i),
        .cpu_adr_i (cpu_adr_i),
        .cpu_dat_i (cpu_dat_i),
        .cpu_gnt_o (cpu_gnt_o),
        .cpu_ack_o (cpu_ack_o),
        .dma_req_i (dma_req_i),
        .dma_gnt_o (dma_gnt_o),
        .dma_stb_i (dma_stb_i),
        .dma_we_i  (dma_we_i),
        .dma_sel_i (dma_sel_i),
        .dma_adr_i (dma_adr_i),
        .dma_dat_i (dma_dat_i),
        .dma_ack_o (dma_ack_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_sel_o  (wb_sel_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_i  (wb_ack_i),
        .bus_tmo_o (bus_tmo_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_p);
        #1;
    endtask

    function automatic int next_owner(input int own, input int last, input logic cyc,
                                      input logic [1:0] req, input logic [1:0] stb);
        logic r, s;
        if (own == OWN_CPU) begin
            if (cyc || req == 2'b00) return OWN_CPU;
            if (req == 2'b11) return (last == 0) ? 1 : 0;
            return req[0] ? 0 : 1;
        end
        if (own == OWN_IDLE) return OWN_CPU;
        r = (own == 0) ? req[0] : req[1];
        s = (own == 0) ? stb[0] : stb[1];
        if (!r && !s) return OWN_IDLE;
        return own;
    endfunction

    function automatic logic owner_stb(input int own, input logic cs, input logic [1:0] ds);
        if (own == OWN_CPU) return cs;
        if (own == 0) return ds[0];
        if (own == 1) return ds[1];
        return 1'b0;
    endfunction

    always @(posedge clk_p or negedge rst_n) begin : mdl
        int   nxt;
        logic s;
        if (!rst_n) begin
            m_own  <= OWN_CPU;
            m_last <= 1;
            m_run  <= 0;
        end else begin
            nxt = next_owner(m_own, m_last, cpu_cyc_i, dma_req_i, dma_stb_i);
            s   = owner_stb(m_own, cpu_stb_i, dma_stb_i);
            if (nxt != m_own || !s || wb_ack_i || (m_run + 1 == TMO)) m_run <= 0;
            else m_run <= m_run + 1;
            if (nxt >= 0 && nxt != m_own) m_last <= nxt;
            m_own <= nxt;
        end
    end

    always @(negedge clk_p) begin : cmp
        logic        b, e_cyc, e_stb, e_we, e_tmo, e_ack;
        logic [1:0]  e_sel;
        logic [15:0] e_adr, e_dat;
        if (rst_n === 1'b1) begin
            b = (m_own == 1);
            if (m_own == OWN_CPU) begin
                e_cyc = cpu_cyc_i; e_stb = cpu_stb_i; e_we = cpu_we_i;
                e_sel = cpu_sel_i; e_adr = cpu_adr_i; e_dat = cpu_dat_i;
            end else if (m_own >= 0) begin
                e_cyc = 1'b1;
                e_stb = b ? dma_stb_i[1] : dma_stb_i[0];
                e_we  = b ? dma_we_i[1]  : dma_we_i[0];
                e_sel = b ? dma_sel_i[3:2] : dma_sel_i[1:0];
                e_adr = b ? dma_adr_i[31:16] : dma_adr_i[15:0];
                e_dat = b ? dma_dat_i[31:16] : dma_dat_i[15:0];
            end else begin
                e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
                e_sel = '0; e_adr = '0; e_dat = '0;
            end
            e_tmo = e_stb && !wb_ack_i && (m_run + 1 == TMO);
            e_ack = wb_ack_i || e_tmo;
            chk("cyc_cpu_gnt", 32'(cpu_gnt_o), 32'(m_own == OWN_CPU));
            chk("cyc_dma_gnt", 32'(dma_gnt_o), 32'({m_own == 1, m_own == 0}));
            chk("cyc_wb_cyc", 32'(wb_cyc_o), 32'(e_cyc));
            chk("cyc_wb_stb", 32'(wb_stb_o), 32'(e_stb));
            if (m_own != OWN_IDLE) begin
                chk("cyc_wb_we", 32'(wb_we_o), 32'(e_we));
                chk("cyc_wb_sel", 32'(wb_sel_o), 32'(e_sel));
                chk("cyc_wb_adr", 32'(wb_adr_o), 32'(e_adr));
                chk("cyc_wb_dat", 32'(wb_dat_o), 32'(e_dat));
            end
            chk("cyc_cpu_ack", 32'(cpu_ack_o), 32'(e_ack && m_own == OWN_CPU));
            chk("cyc_dma_ack", 32'(dma_ack_o), 32'({e_ack && m_own == 1, e_ack && m_own == 0}));
            chk("cyc_bus_tmo", 32'(bus_tmo_o), 32'(e_tmo));
        end
    end

    initial begin
        exp_tok = '{1, 3, 0, 2, 3, 0, 1};

        // Reset with a CPU read of the console status register in progress.
        cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; cpu_adr_i = 16'o177560; cpu_sel_i = 2'b11;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_cpu_gnt", 32'(cpu_gnt_o), 32'd1);
        chk("rst_dma_gnt", 32'(dma_gnt_o), 32'd0);
        chk("rst_bus_tmo", 32'(bus_tmo_o), 32'd0);
        chk("rst_wb_adr", 32'(wb_adr_o), 32'o177560);
        chk("rst_wb_cyc", 32'(wb_cyc_o), 32'd1);
        #6 rst_n = 1'b1;
        step(1);
        wb_ack_i = 1'b1;
        #3;
        chk("cpu_ack_follow", 32'(cpu_ack_o), 32'd1);
        chk("cpu_ack_dma_ack", 32'(dma_ack_o), 32'd0);
        step(1);

        // DMA0 request during a CPU cycle is held off until cpu_cyc_i falls.
        wb_ack_i = 1'b0; cpu_adr_i = 16'o177566; dma_req_i = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("hold_off_gnt", 32'(dma_gnt_o), 32'd0);
            step(1);
        end
        wb_ack_i = 1'b1;
        #3;
        chk("hold_off_ack", 32'(cpu_ack_o), 32'd1);
        step(1);
        cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0; wb_ack_i = 1'b0;
        #3;
        chk("gnt_not_yet", 32'(dma_gnt_o), 32'd0);
        step(1);
        dma_stb_i = 2'b01; dma_we_i = 2'b01; dma_sel_i = 4'b0011;
        dma_adr_i = {16'h0, 16'o001000}; dma_dat_i = {16'h0, 16'hbeef}; wb_ack_i = 1'b1;
        #3;
        chk("dma0_gnt", 32'(dma_gnt_o), 32'b01);
        chk("dma0_cpu_gnt", 32'(cpu_gnt_o), 32'd0);
        chk("dma0_wb_adr", 32'(wb_adr_o), 32'o001000);
        chk("dma0_wb_we", 32'(wb_we_o), 32'd1);
        chk("dma0_wb_dat", 32'(wb_dat_o), 32'hbeef);
        chk("dma0_ack", 32'(dma_ack_o), 32'b01);
        chk("dma0_cpu_ack", 32'(cpu_ack_o), 32'd0);
        step(1);
        dma_req_i = 2'b00; dma_stb_i = 2'b00; dma_we_i = 2'b00; wb_ack_i = 1'b0;
        step(1);
        #2;
        chk("handback_cpu_gnt", 32'(cpu_gnt_o), 32'd0);
        chk("handback_dma_gnt", 32'(dma_gnt_o), 32'd0);
        chk("handback_wb_cyc", 32'(wb_cyc_o), 32'd0);
        step(1);
        #2;
        chk("return_cpu_gnt", 32'(cpu_gnt_o), 32'd1);
        step(1);

        // Asynchronous reset while DMA1 holds the bus drops its grant without a clock.
        dma_req_i = 2'b10;
        step(1);
        chk("dma1_gnt", 32'(dma_gnt_o), 32'b10);
        dma_stb_i = 2'b10;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_dma_gnt", 32'(dma_gnt_o), 32'd0);
        chk("async_rst_cpu_gnt", 32'(cpu_gnt_o), 32'd1);
        dma_req_i = 2'b00; dma_stb_i = 2'b00;
        #2 rst_n = 1'b1;
        step(1);

        // Both DMA masters requesting; each does one transfer then releases.
        cpu_cyc_i = 1'b0; dma_req_i = 2'b11; dma_stb_i = 2'b00; wb_ack_i = 1'b0;
        ntok = 0; prev = 0; done = 2'b00;
        for (int c = 0; c < 40 && ntok < 7; c++) begin
            step(1);
            tok = dma_gnt_o[0] ? 1 : dma_gnt_o[1] ? 2 : cpu_gnt_o ? 0 : 3;
            if (tok != prev && ntok < 7) begin
                toks[ntok] = tok;
                ntok++;
                prev = tok;
            end
            wb_ack_i = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (dma_gnt_o[i]) begin
                    if (!done[i]) begin
                        dma_stb_i[i] = 1'b1; wb_ack_i = 1'b1; done[i] = 1'b1;
                    end else begin
                        dma_stb_i[i] = 1'b0; dma_req_i[i] = 1'b0;
                    end
                end else begin
                    dma_req_i[i] = 1'b1; dma_stb_i[i] = 1'b0; done[i] = 1'b0;
                end
            end
        end
        chk("rr_token_count", 32'(ntok), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < ntok) chk($sformatf("rr_order_%0d", i), 32'(toks[i]), 32'(exp_tok[i]));
        end
        dma_req_i = 2'b00; dma_stb_i = 2'b00; wb_ack_i = 1'b0;
        step(3);

        // DMA0 strobe stalls with no device ack; the last stall ends with a real ack.
        dma_req_i = 2'b01; dma_adr_i = {16'h0, 16'o160000};
        step(1);
        for (int k = 1; k <= 192; k++) begin
            dma_stb_i = 2'b01;
            wb_ack_i  = (k == 192);
            #3;
            e_t = (k == 64) || (k == 128);
            chk($sformatf("tmo_pulse_%0d", k), 32'(bus_tmo_o), 32'(e_t));
            chk($sformatf("tmo_ack_%0d", k), 32'(dma_ack_o), 32'({1'b0, e_t || k == 192}));
            step(1);
        end
        dma_req_i = 2'b00; dma_stb_i = 2'b00; wb_ack_i = 1'b0;
        step(3);

        // Randomized traffic; alternates busy blocks with long-stall blocks.
        stall_mode = 1'b0; ack_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                stall_mode = ($urandom_range(0, 2) == 0);
                ack_pct    = stall_mode ? 0 : int'($urandom_range(20, 80));
            end
            if ($urandom_range(0, stall_mode ? 100 : 3) == 0) cpu_cyc_i = ~cpu_cyc_i;
            cpu_stb_i = cpu_cyc_i & (stall_mode | ($urandom_range(0, 3) != 0));
            cpu_we_i  = 1'($urandom);
            cpu_sel_i = 2'($urandom);
            cpu_adr_i = 16'($urandom);
            cpu_dat_i = 16'($urandom);
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, stall_mode ? 100 : 5) == 0) dma_req_i[i] = ~dma_req_i[i];
                dma_stb_i[i] = dma_gnt_o[i] & (stall_mode | ($urandom_range(0, 1) == 1));
            end
            dma_we_i  = 2'($urandom);
            dma_sel_i = 4'($urandom);
            dma_adr_i = $urandom;
            dma_dat_i = $urandom;
            wb_ack_i  = ($urandom_range(0, 99) < ack_pct);
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
